// File: rtl/clk_mux_monitor_pkg.sv
// Shared types and constants for the clock-mux output monitor.
//   state_t          : monitor FSM states (IDLE/HIGH/LOW/STOP)
//   SRC_*            : 2-bit source-detect codes
//   classify_period  : maps a measured period onto a source code
package clk_mux_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic [1:0] SRC_UNKNOWN = 2'b00;
    localparam logic [1:0] SRC_1       = 2'b01;
    localparam logic [1:0] SRC_2       = 2'b10;
    localparam logic [1:0] SRC_OOR     = 2'b11;

    // Source 1 window is tested first, so overlapping windows resolve to SRC_1.
    function automatic logic [1:0] classify_period(
        input logic [31:0] p,
        input logic [31:0] p1_min,
        input logic [31:0] p1_max,
        input logic [31:0] p2_min,
        input logic [31:0] p2_max
    );
        logic [1:0] src;
        src = SRC_OOR;
        if (p >= p1_min && p <= p1_max) begin
            src = SRC_1;
        end else if (p >= p2_min && p <= p2_max) begin
            src = SRC_2;
        end
        return src;
    endfunction

endpackage

// File: rtl/clk_mux_monitor_cdc_sync_bit.sv
// cdc_sync_bit: single-bit multi-flop synchronizer with async active-low reset.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (chain clears to 0)
//   d     : asynchronous input bit
//   q     : synchronized output, STAGES clk edges after d settles
// Parameters:
//   STAGES : number of flops in the chain (2 or more)
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_mux_monitor.sv
// clk_mux_monitor: receiving-end checker for a glitch-free clock multiplexer.
// Samples the muxed clock as asynchronous data in the clk domain, measures its
// period and phases, identifies the selected source and flags runt pulses,
// a stopped clock and a select mismatch.
//
// Optional feature macro: GLITCH_CAPTURE_EN adds glitch_cnt / glitch_len.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   mon_in     in   muxed clock under test (asynchronous)
//   exp_sel    in   expected select, 0 = source 1, 1 = source 2
//   clr        in   synchronous pulse, clears glitch/mismatch (and glitch_cnt)
//   period     out  last valid measured period in clk cycles
//   period_vld out  one-cycle strobe when period/src_det update
//   src_det    out  00 unknown, 01 source 1, 10 source 2, 11 out of range
//   glitch     out  sticky runt-pulse flag
//   stopped    out  level, no edge seen for TIMEOUT cycles
//   mismatch   out  sticky, src_det valid and disagrees with exp_sel
//   glitch_cnt out  (GLITCH_CAPTURE_EN) saturating runt count
//   glitch_len out  (GLITCH_CAPTURE_EN) phase length of the latest runt
//   fsm_state  out  current FSM state, for observation
//
// Output protocol: period_vld is a pure valid strobe with no ready; period and
// src_det are stable from the strobe until the next strobe (src_det also drops
// to 00 when the clock stops). There is no backpressure.
module clk_mux_monitor
    import clk_mux_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int MIN_PHASE   = 3,
    parameter int TIMEOUT     = 1024,
    parameter int P1_MIN      = 18,
    parameter int P1_MAX      = 22,
    parameter int P2_MIN      = 36,
    parameter int P2_MAX      = 44
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_in,
    input  logic             exp_sel,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic [1:0]       src_det,
    output logic             glitch,
    output logic             stopped,
    output logic             mismatch,
`ifdef GLITCH_CAPTURE_EN
    output logic [7:0]       glitch_cnt,
    output logic [CNT_W-1:0] glitch_len,
`endif
    output logic [1:0]       fsm_state
);

    localparam logic [CNT_W-1:0] MIN_PHASE_C = CNT_W'(MIN_PHASE);
    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic               mon_sync;
    logic               mon_d;
    logic [SYNC_STAGES:0] settle;
    logic               settled;
    logic               rise;
    logic               fall;
    logic               any_edge;

    cdc_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mon_in),
        .q     (mon_sync)
    );

    // The sync chain and mon_d leave reset at 0 regardless of mon_in. If the
    // clock is high when reset releases, that would look like a rise and the
    // first measured period would be partial. Edges are masked until the whole
    // pipeline has been refilled from the real input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_d  <= 1'b0;
            settle <= '0;
        end else begin
            mon_d  <= mon_sync;
            settle <= {settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign settled  = settle[SYNC_STAGES];
    assign rise     = settled &  mon_sync & ~mon_d;
    assign fall     = settled & ~mon_sync &  mon_d;
    assign any_edge = rise | fall;

    // ------------------------------------------------------------------
    // Phase and period counters (saturating)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] ph_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic             short_phase;
    logic             timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_cnt  <= '0;
            per_cnt <= '0;
        end else begin
            if (any_edge) begin
                ph_cnt <= CNT_ONE;
            end else if (ph_cnt != '1) begin
                ph_cnt <= ph_cnt + CNT_ONE;
            end
            if (rise) begin
                per_cnt <= CNT_ONE;
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + CNT_ONE;
            end
        end
    end

    assign short_phase = (ph_cnt < MIN_PHASE_C);
    // An edge in the same cycle takes priority over the timeout.
    assign timeout_hit = (ph_cnt == TIMEOUT_C) && !any_edge;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t next_state;
    logic   discard;
    logic   discard_next;
    logic   glitch_set;
    logic   report;
    logic   stop_set;
    logic   stop_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            discard <= 1'b0;
        end else begin
            state   <= next_state;
            discard <= discard_next;
        end
    end

    always_comb begin
        next_state   = state;
        discard_next = discard;
        glitch_set   = 1'b0;
        report       = 1'b0;
        stop_set     = 1'b0;
        stop_clr     = 1'b0;
        unique case (state)
            IDLE: begin
                // The partial cycle before the first rise is never measured.
                if (rise) begin
                    next_state   = HIGH;
                    discard_next = 1'b0;
                end else if (timeout_hit) begin
                    next_state = STOP;
                    stop_set   = 1'b1;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (short_phase) begin
                        glitch_set   = 1'b1;
                        discard_next = 1'b1;
                    end
                    next_state = LOW;
                end else if (timeout_hit) begin
                    next_state = STOP;
                    stop_set   = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    if (short_phase) begin
                        glitch_set = 1'b1;
                    end else if (!discard) begin
                        report = 1'b1;
                    end
                    discard_next = 1'b0;
                    next_state   = HIGH;
                end else if (timeout_hit) begin
                    next_state = STOP;
                    stop_set   = 1'b1;
                end
            end
            STOP: begin
                // The period that straddles the restart is not trustworthy.
                if (rise) begin
                    next_state   = HIGH;
                    discard_next = 1'b1;
                    stop_clr     = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic mismatch_set;

    // Evaluated one cycle after the strobe, once src_det holds the new code.
    assign mismatch_set = period_vld
                       && (src_det == SRC_1 || src_det == SRC_2)
                       && (src_det != {exp_sel, ~exp_sel});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period     <= '0;
            period_vld <= 1'b0;
            src_det    <= SRC_UNKNOWN;
            stopped    <= 1'b0;
            glitch     <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            period_vld <= report;
            if (report) begin
                period  <= per_cnt;
                src_det <= classify_period(32'(per_cnt), 32'(P1_MIN), 32'(P1_MAX),
                                           32'(P2_MIN), 32'(P2_MAX));
            end else if (stop_set) begin
                src_det <= SRC_UNKNOWN;
            end

            if (stop_set) begin
                stopped <= 1'b1;
            end else if (stop_clr) begin
                stopped <= 1'b0;
            end

            // Setting takes priority over a coincident clear.
            if (glitch_set) begin
                glitch <= 1'b1;
            end else if (clr) begin
                glitch <= 1'b0;
            end

            if (mismatch_set) begin
                mismatch <= 1'b1;
            end else if (clr) begin
                mismatch <= 1'b0;
            end
        end
    end

`ifdef GLITCH_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
            glitch_len <= '0;
        end else begin
            if (glitch_set) begin
                glitch_len <= ph_cnt;
                // A coincident clear restarts the count at this runt.
                if (clr) begin
                    glitch_cnt <= 8'd1;
                end else if (glitch_cnt != 8'hFF) begin
                    glitch_cnt <= glitch_cnt + 8'd1;
                end
            end else if (clr) begin
                glitch_cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_clk_mux_monitor.sv
// Self-checking bench for clk_mux_monitor. Stimulus is a sequence of high/low
// phase lengths on mon_in (directed scenarios plus randomized phases). A
// timestamp-based reference model turns each transition into expected events
// queued with the cycle they must appear; a negedge monitor pops and compares.
// Build with +define+GLITCH_CAPTURE_EN to also cover glitch_cnt/glitch_len.
module tb_clk_mux_monitor;
  import clk_mux_monitor_pkg::*;

  localparam int CNT_W     = 16;
  localparam int MIN_PHASE = 3;
  localparam int TIMEOUT   = 1024;
  localparam int LAT       = 3;  // drive cycle -> registered effect visible

  localparam logic [1:0] K_PERIOD = 2'd0;
  localparam logic [1:0] K_STOP   = 2'd1;
  localparam logic [1:0] K_RUN    = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_in = 1'b0;
  logic exp_sel = 1'b0;
  logic clr = 1'b0;
  logic [CNT_W-1:0] period;
  logic period_vld;
  logic [1:0] src_det;
  logic glitch;
  logic stopped;
  logic mismatch;
  logic [1:0] fsm_state;
`ifdef GLITCH_CAPTURE_EN
  logic [7:0] glitch_cnt;
  logic [CNT_W-1:0] glitch_len;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  clk_mux_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mon_in     (mon_in),
    .exp_sel    (exp_sel),
    .clr        (clr),
    .period     (period),
    .period_vld (period_vld),
    .src_det    (src_det),
    .glitch     (glitch),
    .stopped    (stopped),
    .mismatch   (mismatch),
`ifdef GLITCH_CAPTURE_EN
    .glitch_cnt (glitch_cnt),
    .glitch_len (glitch_len),
`endif
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  kind;
    logic [31:0] period;
    logic [1:0]  src;
    logic        glitch;
    logic        mism;
    logic [7:0]  gcnt;
    logic [31:0] glen;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on transition timestamps: a phase is the gap between consecutive
  // transitions, a period the gap between consecutive rising transitions.
  typedef enum int { M_IDLE, M_HIGH, M_LOW, M_STOP } mstate_t;
  mstate_t m_state;
  logic m_prev;
  int m_last_edge, m_last_rise;
  logic m_disc, m_glitch, m_mism;
  int m_gcnt, m_glen;

  function automatic logic [1:0] ref_src(input int p);
    if (p >= 18 && p <= 22) return 2'b01;
    if (p >= 36 && p <= 44) return 2'b10;
    return 2'b11;
  endfunction

  task automatic model_reset(input int c, input logic level);
    m_state = M_IDLE;
    m_prev = level;
    m_last_edge = c;
    m_last_rise = c;
    m_disc = 1'b0;
    m_glitch = 1'b0;
    m_mism = 1'b0;
    m_gcnt = 0;
    m_glen = 0;
  endtask

  task automatic push(input int c, input logic [1:0] kind, input int p, input logic [1:0] src);
    exp_t e;
    e.cyc = c + LAT;
    e.kind = kind;
    e.period = p;
    e.src = src;
    e.glitch = m_glitch;
    e.mism = m_mism;
    e.gcnt = m_gcnt[7:0];
    e.glen = m_glen;
    exp_q.push_back(e);
  endtask

  task automatic note_glitch(input int phase);
    m_glitch = 1'b1;
    if (m_gcnt < 255) m_gcnt++;
    m_glen = phase;
  endtask

  task automatic model_step(input int c, input logic v);
    int phase, per;
    logic [1:0] src;
    per = 0;
    if (v !== m_prev) begin
      phase = c - m_last_edge;
      m_last_edge = c;
      if (v) begin
        per = c - m_last_rise;
        m_last_rise = c;
      end
      case (m_state)
        M_IDLE: if (v) begin m_state = M_HIGH; m_disc = 1'b0; end
        M_HIGH: if (!v) begin
          if (phase < MIN_PHASE) begin note_glitch(phase); m_disc = 1'b1; end
          m_state = M_LOW;
        end
        M_LOW: if (v) begin
          if (phase < MIN_PHASE) note_glitch(phase);
          else if (!m_disc) begin
            src = ref_src(per);
            if ((src == 2'b01 && exp_sel) || (src == 2'b10 && !exp_sel)) m_mism = 1'b1;
            push(c, K_PERIOD, per, src);
          end
          m_disc = 1'b0;
          m_state = M_HIGH;
        end
        M_STOP: if (v) begin
          m_state = M_HIGH;
          m_disc = 1'b1;
          push(c, K_RUN, 0, 2'b00);
        end
        default: ;
      endcase
    end else if (m_state != M_STOP && (c - m_last_edge) == TIMEOUT) begin
      m_state = M_STOP;
      push(c, K_STOP, 0, 2'b00);
    end
    m_prev = v;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      mon_in = v;
      model_step(cyc, v);
    end
  endtask

  task automatic pattern(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  // Quiet stretch, then a one-cycle clr; optionally changes exp_sel while quiet.
  task automatic clr_pulse(input logic new_sel);
    logic lvl;
    lvl = mon_in;
    drive(lvl, 6);
    @(negedge clk);
    check("pre_clr_glitch", glitch, m_glitch);
    check("pre_clr_mismatch", mismatch, m_mism);
    @(posedge clk);
    #1;
    clr = 1'b1;
    exp_sel = new_sel;
    model_step(cyc, lvl);
    m_glitch = 1'b0;
    m_mism = 1'b0;
    m_gcnt = 0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_step(cyc, lvl);
    @(negedge clk);
    check("post_clr_glitch", glitch, 0);
    check("post_clr_mismatch", mismatch, 0);
`ifdef GLITCH_CAPTURE_EN
    check("post_clr_glitch_cnt", glitch_cnt, 0);
`endif
  endtask

  task automatic check_reset_outputs();
    check("rst_period", period, 0);
    check("rst_period_vld", period_vld, 0);
    check("rst_src_det", src_det, 0);
    check("rst_glitch", glitch, 0);
    check("rst_stopped", stopped, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_state", fsm_state, 0);
`ifdef GLITCH_CAPTURE_EN
    check("rst_glitch_cnt", glitch_cnt, 0);
    check("rst_glitch_len", glitch_len, 0);
`endif
  endtask

  // ---------------- monitor ----------------
  logic stopped_d = 1'b0;
  logic mism_pend = 1'b0;
  logic mism_exp = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stopped_d = 1'b0;
      mism_pend = 1'b0;
    end else begin
      if (mism_pend) begin
        check("mismatch_after_vld", mismatch, mism_exp);
        mism_pend = 1'b0;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missed_event: kind %0d due at cycle %0d, not seen by cycle %0d",
                 exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (period_vld || (stopped !== stopped_d)) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event at cycle %0d: period_vld=%0b stopped=%0b period=%0d, expected none",
                   cyc, period_vld, stopped, period);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          case (e.kind)
            K_PERIOD: begin
              check("period_vld", period_vld, 1);
              check("period", period, e.period);
              check("src_det", src_det, e.src);
              check("stopped_running", stopped, 0);
              mism_pend = 1'b1;
              mism_exp = e.mism;
            end
            K_STOP: begin
              check("stopped_set", stopped, 1);
              check("src_det_stop", src_det, 0);
              check("vld_at_stop", period_vld, 0);
            end
            default: begin
              check("stopped_clear", stopped, 0);
              check("vld_at_restart", period_vld, 0);
            end
          endcase
          check("glitch", glitch, e.glitch);
`ifdef GLITCH_CAPTURE_EN
          check("glitch_cnt", glitch_cnt, e.gcnt);
          check("glitch_len", glitch_len, e.glen);
`endif
        end
      end
      stopped_d = stopped;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int mode, p, h, l;
    model_reset(0, 1'b0);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset(cyc, mon_in);
    drive(1'b0, 8);

    // Source 1 rate, matching select.
    pattern(10, 10, 4);
    // Source 2 rate while source 1 expected -> mismatch, then clear it.
    pattern(20, 20, 3);
    clr_pulse(1'b0);

    // One-cycle runt inside a low phase.
    pattern(10, 10, 2);
    drive(1'b1, 10);
    drive(1'b0, 4);
    drive(1'b1, 1);
    drive(1'b0, 5);
    pattern(10, 10, 3);
    @(negedge clk);
    check("glitch_after_runt", glitch, m_glitch);
    clr_pulse(1'b0);

    // Three 2-cycle runts.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5);
      drive(1'b1, 2);
    end
    drive(1'b0, 8);
    @(negedge clk);
    check("glitch_three_runts", glitch, m_glitch);
`ifdef GLITCH_CAPTURE_EN
    check("glitch_cnt_three", glitch_cnt, m_gcnt);
    check("glitch_len_three", glitch_len, m_glen);
`endif
    pattern(10, 10, 2);
    clr_pulse(1'b0);

    // Stopped clock, then restart.
    pattern(10, 10, 2);
    drive(1'b0, 1100);
    @(negedge clk);
    check("stopped_level", stopped, 1);
    check("src_det_stopped", src_det, 0);
    pattern(10, 10, 4);

    // Randomized phases.
    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: begin p = $urandom_range(18, 22); h = $urandom_range(3, p - 3); l = p - h; end
        1: begin p = $urandom_range(36, 44); h = $urandom_range(3, p - 3); l = p - h; end
        2: begin h = $urandom_range(3, 30); l = $urandom_range(3, 30); end
        3: begin h = $urandom_range(1, 2); l = $urandom_range(3, 12); end
        default: begin h = $urandom_range(3, 12); l = $urandom_range(1, 2); end
      endcase
      drive(1'b1, h);
      drive(1'b0, l);
      if (k % 8 == 7) clr_pulse(1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a high phase.
    pattern(10, 10, 2);
    drive(1'b1, 5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset(cyc, mon_in);
    drive(1'b1, 6);
    drive(1'b0, 10);
    pattern(10, 10, 3);

    drive(1'b0, 20);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d, expected earlier", cyc);
    $fatal(1, "watchdog");
  end

endmodule
